// File: rtl/mips_decode_stage_if.sv
// rtl/mips_decode_stage_if.sv - decode stage bus: instruction in, ALU operands out, write-back port
// Master drives instructions and write-back; slave is the decode stage.
interface mips_decode_stage_if;
  logic [31:0] instr;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  opcode;
  logic [5:0]  func_field;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  dest;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  modport master (
    output instr, in_valid, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, opcode, func_field, A, B, dest
  );

  modport slave (
    input  instr, in_valid, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, opcode, func_field, A, B, dest
  );
endinterface

// File: rtl/mips_decode_stage.sv
// rtl/mips_decode_stage.sv - MIPS decode stage: register file read, immediate select, one-entry output register
// Optional macro DECODE_WB_BYPASS_EN forwards same-edge write-back data into operand reads.
module mips_decode_stage (
  input  logic                 clk,
  input  logic                 rst,
  mips_decode_stage_if.slave   bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  logic [31:0] regs_q [32];

  logic        out_valid_q;
  logic [5:0]  opcode_q, opcode_d;
  logic [5:0]  func_q, func_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  dest_q, dest_d;

  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_val, rt_val, imm_sext;
  logic        accept;
  logic        wb_write;

  assign rs       = bus.instr[25:21];
  assign rt       = bus.instr[20:16];
  assign rd       = bus.instr[15:11];
  assign imm_sext = {{16{bus.instr[15]}}, bus.instr[15:0]};
  assign wb_write = bus.wb_en && (bus.wb_addr != 5'd0);

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    rs_val = regs_q[rs];
    rt_val = regs_q[rt];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_write && (bus.wb_addr == rs)) rs_val = bus.wb_data;
    if (wb_write && (bus.wb_addr == rt)) rt_val = bus.wb_data;
`endif
    if (rs == 5'd0) rs_val = '0;
    if (rt == 5'd0) rt_val = '0;
  end

  always_comb begin
    opcode_d = bus.instr[31:26];
    func_d   = bus.instr[5:0];
    a_d      = rs_val;
    b_d      = rt_val;
    dest_d   = 5'd0;
    if ((opcode_d == OP_LW) || (opcode_d == OP_SW) || (opcode_d == OP_ADDI))
      b_d = imm_sext;
    if (opcode_d == OP_RTYPE)
      dest_d = rd;
    else if ((opcode_d == OP_LW) || (opcode_d == OP_ADDI))
      dest_d = rt;
  end

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_write) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Operands are captured at acceptance, so later write-backs cannot disturb a held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      func_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      dest_q      <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      opcode_q    <= opcode_d;
      func_q      <= func_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dest_q      <= dest_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.opcode     = opcode_q;
  assign bus.func_field = func_q;
  assign bus.A          = a_q;
  assign bus.B          = b_q;
  assign bus.dest       = dest_q;
endmodule
